nes_controller_port: RTL and testbench

- Bus responder for the two NES standard-controller serial ports, sitting at the far end of the 2A03 controller strobes (naddr4016r, naddr4017r, addr4016w).
- Behaves as two 4021-style parallel-in/serial-out shift registers.
- Samples pad buttons while OUT0 is high and serializes them one bit per CPU read of $4016/$4017.
- Drives the result onto the CPU data-in bus.

---
 rtl/nes_controller_port.sv | 114 +++++++++++
 tb/tb_nes_controller_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_port.sv
// NES standard-controller port responder: two 4021-style shift registers that are
// loaded while OUT0 is high and advance one bit on each $4016/$4017 read strobe release.
module nes_controller_port #(
    parameter logic [2:0] OPEN_BUS    = 3'b010,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       naddr4016r,
    input  logic       naddr4017r,
    input  logic [2:0] addr4016w,
    input  logic [7:0] pad1_buttons,
    input  logic [7:0] pad2_buttons,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [3:0] pad1_count,
    output logic [3:0] pad2_count
);

    localparam logic [3:0] COUNT_MAX = 4'd8;

    logic       out0;
    logic       unused_write_bits;
    logic [7:0] pad_in   [2];
    logic       strobe_n [2];
    logic       ser      [2];
    logic [3:0] count    [2];

    assign out0              = addr4016w[0];
    assign unused_write_bits = ^addr4016w[2:1];

    assign pad_in[0]   = pad1_buttons;
    assign pad_in[1]   = pad2_buttons;
    assign strobe_n[0] = naddr4016r;
    assign strobe_n[1] = naddr4017r;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [7:0] sync_reg [SYNC_STAGES];
            logic [7:0] synced;
            logic [7:0] shift_reg;
            logic [7:0] shift_next;
            logic [3:0] count_reg;
            logic [3:0] count_next;
            logic       prev_reg;
            logic       strobe_release;

            // Button synchronizer: raw pad pins are asynchronous to the CPU clock.
            always_ff @(posedge clock) begin
                if (!nreset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_reg[i] <= 8'h00;
                    end
                end else begin
                    sync_reg[0] <= pad_in[gi];
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_reg[i] <= sync_reg[i-1];
                    end
                end
            end

            assign synced = sync_reg[SYNC_STAGES-1];

            // Shift only on the low-to-high edge of the read strobe, so a long read shifts once.
            assign strobe_release = !prev_reg && strobe_n[gi];

            always_comb begin
                shift_next = shift_reg;
                count_next = count_reg;
                if (out0) begin
                    shift_next = synced;
                    count_next = 4'd0;
                end else if (strobe_release) begin
                    shift_next = {1'b1, shift_reg[7:1]};
                    count_next = (count_reg >= COUNT_MAX) ? COUNT_MAX : count_reg + 4'd1;
                end
            end

            always_ff @(posedge clock) begin
                if (!nreset) begin
                    shift_reg <= 8'h00;
                    count_reg <= 4'd0;
                    prev_reg  <= 1'b1;
                end else begin
                    shift_reg <= shift_next;
                    count_reg <= count_next;
                    prev_reg  <= strobe_n[gi];
                end
            end

            // While OUT0 is high the 4021 is transparent: the A button appears directly.
            assign ser[gi]   = out0 ? synced[0] : shift_reg[0];
            assign count[gi] = count_reg;
        end
    endgenerate

    assign pad1_count = count[0];
    assign pad2_count = count[1];

    // Port 1 wins if both strobes are low; the upper bits mimic open-bus $40.
    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        if (!naddr4016r) begin
            data_out = {OPEN_BUS, 4'b0000, ser[0]};
            data_oe  = 1'b1;
        end else if (!naddr4017r) begin
            data_out = {OPEN_BUS, 4'b0000, ser[1]};
            data_oe  = 1'b1;
        end
    end

endmodule

// File: tb/tb_nes_controller_port.sv
// Scoreboard bench for nes_controller_port: stimulus queues expected read responses,
// a negedge monitor pops one entry for every cycle the port drives the bus.
module tb_nes_controller_port;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       naddr4016r = 1'b1;
    logic       naddr4017r = 1'b1;
    logic [2:0] addr4016w = 3'b000;
    logic [7:0] pad1_buttons = 8'h00;
    logic [7:0] pad2_buttons = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic [3:0] pad1_count;
    logic [3:0] pad2_count;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] c1;
        logic [3:0] c2;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    nes_controller_port #(
        .OPEN_BUS   (3'b010),
        .SYNC_STAGES(2)
    ) dut (
        .clock       (clock),
        .nreset      (nreset),
        .naddr4016r  (naddr4016r),
        .naddr4017r  (naddr4017r),
        .addr4016w   (addr4016w),
        .pad1_buttons(pad1_buttons),
        .pad2_buttons(pad2_buttons),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .pad1_count  (pad1_count),
        .pad2_count  (pad2_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_read(input logic [7:0] dv, input logic [3:0] c1v, input logic [3:0] c2v);
        exp_q.push_back(exp_t'{d: dv, c1: c1v, c2: c2v});
    endtask

    // One-cycle read strobe followed by one high cycle so the release edge is seen.
    task automatic do_read(input int port, input logic [7:0] dv, input logic [3:0] c1v,
                           input logic [3:0] c2v);
        expect_read(dv, c1v, c2v);
        if (port == 1) naddr4016r = 1'b0;
        else           naddr4017r = 1'b0;
        tick();
        naddr4016r = 1'b1;
        naddr4017r = 1'b1;
        tick();
    endtask

    task automatic reload_pulse();
        addr4016w[0] = 1'b1;
        tick();
        addr4016w[0] = 1'b0;
    endtask

    // Monitor: every bus-driving cycle must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (data_oe) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got data_out=%02h, required no bus drive", data_out);
                end else begin
                    e = exp_q.pop_front();
                    $display("read data_out=%02h pad1_count=%0d pad2_count=%0d (want %02h %0d %0d)",
                             data_out, pad1_count, pad2_count, e.d, e.c1, e.c2);
                    check("read_data", {24'h0, data_out}, {24'h0, e.d});
                    check("read_count1", {28'h0, pad1_count}, {28'h0, e.c1});
                    check("read_count2", {28'h0, pad2_count}, {28'h0, e.c2});
                end
            end
        end
    end

    initial begin
        logic [7:0] seq;
        seq = 8'b1000_0101;

        // Reset with idle strobes
        tick();
        tick();
        check("reset_data_out", {24'h0, data_out}, 32'h00);
        check("reset_data_oe", {31'h0, data_oe}, 32'h0);
        check("reset_count1", {28'h0, pad1_count}, 32'h0);
        check("reset_count2", {28'h0, pad2_count}, 32'h0);
        nreset = 1'b1;
        tick();

        // Full read of port 1: A, B, Select, Start, Up, Down, Left, Right
        pad1_buttons = 8'b1000_0101;
        repeat (3) tick();
        reload_pulse();
        for (int i = 0; i < 8; i++) begin
            do_read(1, {7'b0100000, seq[i]}, i[3:0], 4'd0);
        end
        check("full_read_count1", {28'h0, pad1_count}, 32'd8);

        // Over-read: ones shift in, count saturates
        for (int i = 0; i < 3; i++) begin
            do_read(1, 8'h41, 4'd8, 4'd0);
        end
        check("over_read_count1", {28'h0, pad1_count}, 32'd8);
        check("over_read_count2", {28'h0, pad2_count}, 32'd0);

        // Held $4017 strobe shifts once
        pad2_buttons = 8'h02;
        repeat (3) tick();
        reload_pulse();
        repeat (4) expect_read(8'h40, 4'd0, 4'd0);
        naddr4017r = 1'b0;
        repeat (4) tick();
        naddr4017r = 1'b1;
        tick();
        check("held_strobe_count2", {28'h0, pad2_count}, 32'd1);
        do_read(2, 8'h41, 4'd0, 4'd1);

        // OUT0 high: live A with two-cycle sync latency, no counting
        addr4016w[0] = 1'b1;
        pad1_buttons = 8'h00;
        repeat (3) tick();
        expect_read(8'h40, 4'd0, 4'd0);
        expect_read(8'h40, 4'd0, 4'd0);
        expect_read(8'h41, 4'd0, 4'd0);
        naddr4016r   = 1'b0;
        pad1_buttons = 8'h01;
        repeat (3) tick();
        naddr4016r = 1'b1;
        tick();
        expect_read(8'h41, 4'd0, 4'd0);
        expect_read(8'h41, 4'd0, 4'd0);
        expect_read(8'h40, 4'd0, 4'd0);
        naddr4016r   = 1'b0;
        pad1_buttons = 8'h00;
        repeat (3) tick();
        naddr4016r = 1'b1;
        tick();
        check("out0_high_count1", {28'h0, pad1_count}, 32'd0);

        // Collision: both strobes low, port 1 wins, both shift
        pad1_buttons = 8'h01;
        pad2_buttons = 8'h00;
        repeat (3) tick();
        addr4016w[0] = 1'b0;
        expect_read(8'h41, 4'd0, 4'd0);
        naddr4016r = 1'b0;
        naddr4017r = 1'b0;
        tick();
        naddr4016r = 1'b1;
        naddr4017r = 1'b1;
        tick();
        check("collision_count1", {28'h0, pad1_count}, 32'd1);
        check("collision_count2", {28'h0, pad2_count}, 32'd1);
        do_read(1, 8'h40, 4'd1, 4'd1);
        do_read(1, 8'h40, 4'd2, 4'd1);
        check("pre_reset_count1", {28'h0, pad1_count}, 32'd3);

        // Reset mid-sequence with the strobe low through reset release
        expect_read(8'h40, 4'd3, 4'd1);
        expect_read(8'h40, 4'd0, 4'd0);
        nreset     = 1'b0;
        naddr4016r = 1'b0;
        repeat (2) tick();
        nreset     = 1'b1;
        naddr4016r = 1'b1;
        tick();
        check("post_reset_count1", {28'h0, pad1_count}, 32'd0);
        check("post_reset_count2", {28'h0, pad2_count}, 32'd0);
        do_read(1, 8'h40, 4'd0, 4'd0);
        check("post_reset_read_count1", {28'h0, pad1_count}, 32'd1);
        check("idle_data_out", {24'h0, data_out}, 32'h00);
        check("idle_data_oe", {31'h0, data_oe}, 32'h0);

        tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
